// File: rtl/acc_stream_out_if.sv
// Bundle between the accumulator output stage, the stream serializer and the
// unified-buffer / host stream side.
interface acc_stream_out_if #(
  parameter int ACC_WIDTH  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
);
  localparam int IW = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                                  acc_valid_i;
  logic [0:ACC_WIDTH-1][DATA_WIDTH-1:0]  acc_mem_in;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [DATA_WIDTH-1:0]                 out_data;
  logic                                  out_last;
  logic [IW-1:0]                         out_index;
  logic [CW-1:0]                         fifo_count;
  logic                                  ovf_o;

  modport master (
    output acc_valid_i, acc_mem_in, out_ready,
    input  out_valid, out_data, out_last, out_index, fifo_count, ovf_o
  );

  modport slave (
    input  acc_valid_i, acc_mem_in, out_ready,
    output out_valid, out_data, out_last, out_index, fifo_count, ovf_o
  );
endinterface

// File: rtl/acc_stream_out.sv
// Vector FIFO that buffers accumulator result vectors and serializes them,
// element 0 first, onto a single valid/ready element stream.

// One element column of the vector FIFO: DEPTH entries of one element each.
module acc_stream_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2,
  parameter int PW         = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         wr_ptr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         rd_ptr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

module acc_stream_out #(
  parameter int ACC_WIDTH  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
) (
  input  logic             clk,
  input  logic             rst,
  acc_stream_out_if.slave  bus
);
  localparam int IW = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ACC_WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [IW-1:0]         index;
  } beat_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] elem_cnt;
  logic [CW-1:0] count;
  logic          ovf;
  logic          valid, fire, pop, push, drop;
  beat_t         beat;

  logic [ACC_WIDTH-1:0][DATA_WIDTH-1:0] lane_q;

  // A full FIFO can still take a vector on the cycle its head vector retires.
  assign valid = (count != '0);
  assign fire  = valid && bus.out_ready;
  assign pop   = fire && (elem_cnt == LAST_IDX);
  assign push  = bus.acc_valid_i && ((count < FULL_CNT) || pop);
  assign drop  = bus.acc_valid_i && !push;

  genvar g;
  generate
    for (g = 0; g < ACC_WIDTH; g++) begin : g_lane
      acc_stream_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PW         (PW)
      ) u_lane (
        .clk    (clk),
        .we     (push),
        .wr_ptr (wr_ptr),
        .wdata  (bus.acc_mem_in[g]),
        .rd_ptr (rd_ptr),
        .rdata  (lane_q[g])
      );
    end
  endgenerate

  // elem_cnt is the stream state: IDLE when count==0, else STREAM(elem_cnt).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      elem_cnt <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) begin
        if (elem_cnt == LAST_IDX) begin
          elem_cnt <= '0;
          rd_ptr   <= rd_ptr + 1'b1;
        end else begin
          elem_cnt <= elem_cnt + 1'b1;
        end
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  always_comb begin
    beat = '0;
    if (valid) begin
      beat.data  = lane_q[elem_cnt];
      beat.last  = (elem_cnt == LAST_IDX);
      beat.index = elem_cnt;
    end
  end

  assign bus.out_valid  = valid;
  assign bus.out_data   = beat.data;
  assign bus.out_last   = beat.last;
  assign bus.out_index  = beat.index;
  assign bus.fifo_count = count;
  assign bus.ovf_o      = ovf;
endmodule

// File: tb/tb_acc_stream_out.sv
// Directed bench for acc_stream_out: a queue-of-vectors model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_acc_stream_out;
  localparam int AW = 4, DW = 16, DP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acc_stream_out_if #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) bus();

  acc_stream_out #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: list of buffered vectors plus the position within the head vector.
  typedef logic [AW-1:0][DW-1:0] vec_t;
  vec_t mq[$];
  int   mpos = 0;
  bit   movf = 1'b0;

  task automatic model_clear();
    mq.delete();
    mpos = 0;
    movf = 1'b0;
  endtask

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    if (!rst) begin
      model_clear();
    end else begin
      bit retire;
      vec_t v;
      retire = 1'b0;
      if (mq.size() > 0 && bus.out_ready) begin
        if (mpos == AW - 1) begin
          retire = 1'b1;
          mpos = 0;
        end else begin
          mpos++;
        end
      end
      if (bus.acc_valid_i) begin
        if (mq.size() < DP || retire) begin
          for (int e = 0; e < AW; e++) v[e] = bus.acc_mem_in[e];
          if (retire) void'(mq.pop_front());
          mq.push_back(v);
          retire = 1'b0;
        end else begin
          movf = 1'b1;
        end
      end
      if (retire) void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    vec_t h;
    logic [DW-1:0] ed;
    logic          el;
    int            ei;
    ed = '0; el = 1'b0; ei = 0;
    if (mq.size() > 0) begin
      h  = mq[0];
      ed = h[mpos];
      el = (mpos == AW - 1);
      ei = mpos;
    end
    check("m_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    check("m_data",  {16'd0, bus.out_data}, {16'd0, ed});
    check("m_last",  {31'd0, bus.out_last}, {31'd0, el});
    check("m_index", {30'd0, bus.out_index}, ei);
    check("m_count", {30'd0, bus.fifo_count}, mq.size());
    check("m_ovf",   {31'd0, bus.ovf_o}, {31'd0, movf});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [DW-1:0] a, b, c, d);
    bus.acc_valid_i   = 1'b1;
    bus.acc_mem_in[0] = a;
    bus.acc_mem_in[1] = b;
    bus.acc_mem_in[2] = c;
    bus.acc_mem_in[3] = d;
    tick();
    bus.acc_valid_i = 1'b0;
    bus.acc_mem_in  = {$urandom, $urandom};
  endtask

  logic [DW-1:0] exp_seq [12];

  initial begin
    bus.acc_valid_i = 1'b0;
    bus.acc_mem_in  = '0;
    bus.out_ready   = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", {31'd0, bus.out_valid}, 0);
    check("rst_count", {30'd0, bus.fifo_count}, 0);
    check("rst_ovf",   {31'd0, bus.ovf_o}, 0);
    rst = 1'b1;
    tick();

    // Reset mid-stream
    push_vec(16'd1, 16'd2, 16'd3, 16'd4);
    check("mid_d0", {16'd0, bus.out_data}, 32'd1);
    bus.out_ready = 1'b1;
    tick(); tick();
    check("mid_idx2", {30'd0, bus.out_index}, 2);
    check("mid_d2", {16'd0, bus.out_data}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 0);
    check("arst_data",  {16'd0, bus.out_data}, 0);
    check("arst_index", {30'd0, bus.out_index}, 0);
    check("arst_count", {30'd0, bus.fifo_count}, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_count", {30'd0, bus.fifo_count}, 0);
    check("post_ovf",   {31'd0, bus.ovf_o}, 0);

    // Basic serialize
    bus.out_ready = 1'b1;
    push_vec(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    for (int i = 0; i < 4; i++) begin
      check("ser_data",  {16'd0, bus.out_data}, 32'h11 * (i + 1));
      check("ser_index", {30'd0, bus.out_index}, i);
      check("ser_last",  {31'd0, bus.out_last}, {31'd0, i == 3});
      tick();
    end
    check("ser_idle", {31'd0, bus.out_valid}, 0);

    // Backpressure
    bus.out_ready = 1'b0;
    push_vec(16'd5, 16'd6, 16'd7, 16'd8);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_d", {16'd0, bus.out_data}, 32'd5);
      check("bp_hold_i", {30'd0, bus.out_index}, 0);
      if (i < 2) tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_data", {16'd0, bus.out_data}, 32'd5 + i);
      tick();
    end
    check("bp_idle", {31'd0, bus.out_valid}, 0);

    // Fill and overflow
    bus.out_ready = 1'b0;
    push_vec(16'hA000, 16'hA001, 16'hA002, 16'hA003);
    push_vec(16'hB000, 16'hB001, 16'hB002, 16'hB003);
    push_vec(16'hC000, 16'hC001, 16'hC002, 16'hC003);
    check("ovf_count", {30'd0, bus.fifo_count}, 2);
    check("ovf_flag",  {31'd0, bus.ovf_o}, 1);
    exp_seq = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                16'hB000, 16'hB001, 16'hB002, 16'hB003, 0, 0, 0, 0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", {16'd0, bus.out_data}, {16'd0, exp_seq[i]});
      tick();
    end
    check("ovf_idle",   {31'd0, bus.out_valid}, 0);
    check("ovf_sticky", {31'd0, bus.ovf_o}, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Simultaneous push and final pop
    bus.out_ready = 1'b0;
    push_vec(16'hA000, 16'hA001, 16'hA002, 16'hA003);
    push_vec(16'hB000, 16'hB001, 16'hB002, 16'hB003);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    check("sim_last",  {31'd0, bus.out_last}, 1);
    check("sim_full",  {30'd0, bus.fifo_count}, 2);
    push_vec(16'hC000, 16'hC001, 16'hC002, 16'hC003);
    check("sim_count", {30'd0, bus.fifo_count}, 2);
    check("sim_ovf",   {31'd0, bus.ovf_o}, 0);
    exp_seq = '{16'hB000, 16'hB001, 16'hB002, 16'hB003,
                16'hC000, 16'hC001, 16'hC002, 16'hC003, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      check("sim_seq", {16'd0, bus.out_data}, {16'd0, exp_seq[i]});
      tick();
    end
    check("sim_idle", {31'd0, bus.out_valid}, 0);

    // Pointer wrap, gap-free across vector boundaries
    for (int k = 0; k < 5; k++) begin
      push_vec(DW'(16'h100 * k + 16'h50), DW'(16'h100 * k + 16'h51),
               DW'(16'h100 * k + 16'h52), DW'(16'h100 * k + 16'h53));
      check("wrap_head", {16'd0, bus.out_data}, 32'h100 * k + 32'h50);
      tick(); tick(); tick();
    end
    tick();
    check("wrap_count", {30'd0, bus.fifo_count}, 0);
    check("wrap_idle",  {31'd0, bus.out_valid}, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
